fp_mul_pipe: RTL and testbench

- Parametrised, 3-stage pipelined floating-point multiplier with valid/ready handshake.
- Successor to the single-precision combinational multiplier: generic exponent/fraction widths, five rounding modes, backpressure, registered flags.
- Sits in the ALU datapath between the operand issue stage and the FPU result writeback arbiter.

---
 rtl/fp_pkg.sv | 64 ++++++
 rtl/fp_mul_pipe_round.sv | 64 ++++++
 rtl/fp_mul_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier and its
// round-and-pack stage.
package fp_pkg;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rmode_e;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_e;

    // Result decided by operand classes alone; SP_NONE means use the arithmetic path.
    typedef enum logic [1:0] {
        SP_NONE = 2'd0,
        SP_NAN  = 2'd1,
        SP_INF  = 2'd2,
        SP_ZERO = 2'd3
    } special_e;

    typedef struct packed {
        logic     sign;
        rmode_e   mode;
        special_e spec;
    } ctrl_t;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic logic [63:0] fp_qnan(input int exp_w, input int frc_w);
        return (((64'd1 << exp_w) - 64'd1) << frc_w) | (64'd1 << (frc_w - 1));
    endfunction

    function automatic rmode_e decode_rmode(input logic [2:0] m);
        case (m)
            3'd1:    return RTZ;
            3'd2:    return RDN;
            3'd3:    return RUP;
            3'd4:    return RMM;
            default: return RNE;
        endcase
    endfunction

    function automatic special_e special_of(input fp_class_e cx, input fp_class_e cy);
        if (cx == NAN || cy == NAN)
            return SP_NAN;
        if ((cx == INF && cy == ZERO) || (cx == ZERO && cy == INF))
            return SP_NAN;
        if (cx == INF || cy == INF)
            return SP_INF;
        if (cx == ZERO || cy == ZERO)
            return SP_ZERO;
        return SP_NONE;
    endfunction

endpackage

// File: rtl/fp_mul_pipe_round.sv
// Combinational round-and-pack: normalised sign/exponent/mantissa plus guard and
// sticky in, packed result with overflow/underflow flags out. Shared with the adder.
module fp_round
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int FRC_W = 23
) (
    input  logic                      sign,
    input  logic signed [EXP_W+1:0]   e,
    input  logic [FRC_W-1:0]          kept,
    input  logic                      g,
    input  logic                      s,
    input  rmode_e                    mode,
    output logic [EXP_W+FRC_W:0]      fp_z,
    output logic                      ovrf,
    output logic                      udrf
);

    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic signed [EW-1:0] E_ZERO = EW'(0);
    localparam logic signed [EW-1:0] E_ALL1 = {2'b00, {EXP_W{1'b1}}};

    logic                  inc;
    logic [FRC_W:0]        mant;
    logic signed [EW-1:0]  e_r;
    logic                  keep_finite;

    always_comb begin
        inc = 1'b0;
        case (mode)
            RNE:     inc = g && (s || kept[0]);
            RTZ:     inc = 1'b0;
            RDN:     inc = sign && (g || s);
            RUP:     inc = !sign && (g || s);
            RMM:     inc = g;
            default: inc = g && (s || kept[0]);
        endcase
    end

    // A carry out of the mantissa leaves the fraction at zero, so only e moves.
    assign mant = {1'b0, kept} + {{FRC_W{1'b0}}, inc};
    assign e_r  = mant[FRC_W] ? e + E_ONE : e;

    assign keep_finite = (mode == RTZ) || (mode == RDN && !sign) || (mode == RUP && sign);

    always_comb begin
        fp_z = {sign, e_r[EXP_W-1:0], mant[FRC_W-1:0]};
        ovrf = 1'b0;
        udrf = 1'b0;
        if (e_r >= E_ALL1) begin
            ovrf = 1'b1;
            if (keep_finite)
                fp_z = {sign, {(EXP_W-1){1'b1}}, 1'b0, {FRC_W{1'b1}}};
            else
                fp_z = {sign, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
        end else if (e_r <= E_ZERO) begin
            udrf = 1'b1;
            fp_z = {sign, {(EXP_W+FRC_W){1'b0}}};
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier (classify/multiply, normalise,
// round/pack). Optional sticky overflow/underflow flags under FP_MUL_STICKY_FLAGS_EN.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int FRC_W = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_W+FRC_W:0]  fp_X,
    input  logic [EXP_W+FRC_W:0]  fp_Y,
    input  logic [2:0]            r_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+FRC_W:0]  fp_Z,
    output logic                  ovrf,
`ifdef FP_MUL_STICKY_FLAGS_EN
    input  logic                  flag_clr,
    output logic                  ovrf_sticky,
    output logic                  udrf_sticky,
`endif
    output logic                  udrf
);

    localparam int W    = 1 + EXP_W + FRC_W;
    localparam int EW   = EXP_W + 2;
    localparam int PW   = 2 * FRC_W + 2;
    localparam int BIAS = fp_bias(EXP_W);
    localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic [63:0]          QNAN64 = fp_qnan(EXP_W, FRC_W);
    localparam logic [W-1:0]         QNAN   = QNAN64[W-1:0];

    typedef struct packed {
        ctrl_t                ctrl;
        logic signed [EW-1:0] e;
        logic [PW-1:0]        p;
    } s1_t;

    typedef struct packed {
        ctrl_t                ctrl;
        logic signed [EW-1:0] e;
        logic [FRC_W-1:0]     kept;
        logic                 g;
        logic                 s;
    } s2_t;

    typedef struct packed {
        logic [W-1:0] z;
        logic         ovrf;
        logic         udrf;
    } s3_t;

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [FRC_W-1:0] f);
        if (e == '0)
            return ZERO;
        if (e == '1)
            return (f == '0) ? INF : NAN;
        return NORM;
    endfunction

    logic v1, v2, v3;
    logic en1, en2, en3;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    s3_t  s3_d, s3_q;

    // Handshake: a beat moves on valid && ready at the clock edge. Each stage
    // register loads when it is empty or its contents move on in the same cycle;
    // in_ready therefore depends on out_ready and never on in_valid.
    assign en3      = !v3 || out_ready;
    assign en2      = !v2 || en3;
    assign en1      = !v1 || en2;
    assign in_ready = en1;

    logic [EXP_W-1:0] ex, ey;
    logic [FRC_W-1:0] fx, fy;
    logic [PW-1:0]    mx, my;

    assign ex = fp_X[W-2 -: EXP_W];
    assign ey = fp_Y[W-2 -: EXP_W];
    assign fx = fp_X[FRC_W-1:0];
    assign fy = fp_Y[FRC_W-1:0];
    assign mx = {{(FRC_W+1){1'b0}}, 1'b1, fx};
    assign my = {{(FRC_W+1){1'b0}}, 1'b1, fy};

    always_comb begin
        s1_d           = '0;
        s1_d.ctrl.sign = fp_X[W-1] ^ fp_Y[W-1];
        s1_d.ctrl.mode = decode_rmode(r_mode);
        s1_d.ctrl.spec = special_of(classify(ex, fx), classify(ey, fy));
        s1_d.e         = $signed({2'b00, ex}) + $signed({2'b00, ey}) - BIAS_E;
        s1_d.p         = mx * my;
    end

    // Product lies in [1,4); bring the leading one to the bit just above the kept field.
    logic [PW-2:0] pn;
    assign pn = s1_q.p[PW-1] ? s1_q.p[PW-2:0] : {s1_q.p[PW-3:0], 1'b0};

    always_comb begin
        s2_d      = '0;
        s2_d.ctrl = s1_q.ctrl;
        s2_d.e    = s1_q.p[PW-1] ? s1_q.e + E_ONE : s1_q.e;
        s2_d.kept = pn[PW-2 -: FRC_W];
        s2_d.g    = pn[FRC_W];
        s2_d.s    = |pn[FRC_W-1:0];
    end

    logic [W-1:0] rnd_z;
    logic         rnd_o, rnd_u;

    fp_round #(
        .EXP_W (EXP_W),
        .FRC_W (FRC_W)
    ) u_round (
        .sign (s2_q.ctrl.sign),
        .e    (s2_q.e),
        .kept (s2_q.kept),
        .g    (s2_q.g),
        .s    (s2_q.s),
        .mode (s2_q.ctrl.mode),
        .fp_z (rnd_z),
        .ovrf (rnd_o),
        .udrf (rnd_u)
    );

    always_comb begin
        s3_d = '{z: rnd_z, ovrf: rnd_o, udrf: rnd_u};
        case (s2_q.ctrl.spec)
            SP_NAN:  s3_d = '{z: QNAN, ovrf: 1'b0, udrf: 1'b0};
            SP_INF:  s3_d = '{z: {s2_q.ctrl.sign, {EXP_W{1'b1}}, {FRC_W{1'b0}}}, ovrf: 1'b0, udrf: 1'b0};
            SP_ZERO: s3_d = '{z: {s2_q.ctrl.sign, {(EXP_W+FRC_W){1'b0}}}, ovrf: 1'b0, udrf: 1'b0};
            default: s3_d = '{z: rnd_z, ovrf: rnd_o, udrf: rnd_u};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            if (en1) begin
                v1 <= in_valid;
                if (in_valid)
                    s1_q <= s1_d;
            end
            if (en2) begin
                v2 <= v1;
                if (v1)
                    s2_q <= s2_d;
            end
            if (en3) begin
                v3 <= v2;
                if (v2)
                    s3_q <= s3_d;
            end
        end
    end

    assign out_valid = v3;
    assign fp_Z      = s3_q.z;
    assign ovrf      = s3_q.ovrf;
    assign udrf      = s3_q.udrf;

`ifdef FP_MUL_STICKY_FLAGS_EN
    logic xfer;
    logic sticky_o, sticky_u, pend_o, pend_u;

    assign xfer = v3 && out_ready;

    // A flag arriving with flag_clr is parked for one cycle so the clear cannot swallow it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_o <= 1'b0;
            sticky_u <= 1'b0;
            pend_o   <= 1'b0;
            pend_u   <= 1'b0;
        end else if (flag_clr) begin
            sticky_o <= 1'b0;
            sticky_u <= 1'b0;
            pend_o   <= xfer && s3_q.ovrf;
            pend_u   <= xfer && s3_q.udrf;
        end else begin
            sticky_o <= sticky_o || pend_o || (xfer && s3_q.ovrf);
            sticky_u <= sticky_u || pend_u || (xfer && s3_q.udrf);
            pend_o   <= 1'b0;
            pend_u   <= 1'b0;
        end
    end

    assign ovrf_sticky = sticky_o;
    assign udrf_sticky = sticky_u;
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe at binary32 widths: latency, rounding modes,
// overflow/underflow, specials, backpressure and reset while busy.
module tb_fp_mul_pipe;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] fp_X;
    logic [W-1:0] fp_Y;
    logic [2:0]   r_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] fp_Z;
    logic         ovrf;
    logic         udrf;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    logic [W+1:0] exp_q[$];
    logic [W+1:0] mon_exp;

    fp_mul_pipe #(
        .EXP_W (8),
        .FRC_W (23)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fp_X      (fp_X),
        .fp_Y      (fp_Y),
        .r_mode    (r_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fp_Z      (fp_Z),
        .ovrf      (ovrf),
        .udrf      (udrf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached with %0d results pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // driver: present one operand pair and hold it until accepted
    task automatic put(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                       input logic [31:0] z, input logic o, input logic u);
        logic acc;
        int   n;
        acc      = 1'b0;
        n        = 0;
        in_valid = 1'b1;
        fp_X     = x;
        fp_Y     = y;
        r_mode   = m;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (acc)
            exp_q.push_back({z, o, u});
        else
            check("accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // scoreboard: every output transfer must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'(fp_Z), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_exp = exp_q.pop_front();
                check($sformatf("result%0d", n_out), 64'({fp_Z, ovrf, udrf}), 64'(mon_exp));
                n_out++;
            end
        end
    end

    int stale;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        fp_X      = '0;
        fp_Y      = '0;
        r_mode    = 3'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_fp_z",      64'(fp_Z),      64'd0);
        check("rst_ovrf",      64'(ovrf),      64'd0);
        check("rst_udrf",      64'(udrf),      64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        #1;

        // latency: result appears in the third cycle after acceptance
        put(32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 1'b0, 1'b0);
        @(negedge clk);
        check("lat_cycle1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_cycle2", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_cycle3", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        wait_drain("drain_basic");

        // back-to-back directed vectors
        put(32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 1'b0, 1'b0);
        put(32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 1'b0, 1'b0);
        put(32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 1'b0, 1'b0);
        put(32'h7F000000, 32'h7F000000, 3'd0, 32'h7F800000, 1'b1, 1'b0);
        put(32'h7F000000, 32'h7F000000, 3'd1, 32'h7F7FFFFF, 1'b1, 1'b0);
        put(32'hFF000000, 32'h7F000000, 3'd3, 32'hFF7FFFFF, 1'b1, 1'b0);
        put(32'hFF000000, 32'h7F000000, 3'd2, 32'hFF800000, 1'b1, 1'b0);
        put(32'h00800000, 32'h00800000, 3'd0, 32'h00000000, 1'b0, 1'b1);
        put(32'h00000001, 32'h3F800000, 3'd0, 32'h00000000, 1'b0, 1'b0);
        put(32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 1'b0, 1'b0);
        put(32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 1'b0, 1'b0);
        put(32'h7F800000, 32'hC0000000, 3'd0, 32'hFF800000, 1'b0, 1'b0);
        put(32'h80000000, 32'h3F800000, 3'd0, 32'h80000000, 1'b0, 1'b0);
        put(32'h3F800003, 32'h3FC00000, 3'd0, 32'h3FC00004, 1'b0, 1'b0);
        put(32'h3F800003, 32'h3FC00000, 3'd4, 32'h3FC00005, 1'b0, 1'b0);
        put(32'hBF800003, 32'h3FC00000, 3'd2, 32'hBFC00005, 1'b0, 1'b0);
        put(32'h3F800003, 32'h3FC00000, 3'd7, 32'h3FC00004, 1'b0, 1'b0);
        put(32'h3FB504F3, 32'h3FB504F3, 3'd3, 32'h40000000, 1'b0, 1'b0);
        put(32'h3FB504F3, 32'h3FB504F3, 3'd0, 32'h3FFFFFFF, 1'b0, 1'b0);
        put(32'h7F000000, 32'h3F800000, 3'd0, 32'h7F000000, 1'b0, 1'b0);
        put(32'h7F000000, 32'h40000000, 3'd0, 32'h7F800000, 1'b1, 1'b0);
        put(32'h20000000, 32'h1F800000, 3'd0, 32'h00000000, 1'b0, 1'b1);
        put(32'h20000000, 32'h20000000, 3'd0, 32'h00800000, 1'b0, 1'b0);
        wait_drain("drain_vectors");

        // backpressure: six operations against a stalled consumer
        out_ready = 1'b0;
        fork
            begin
                put(32'h40000000, 32'h3F800000, 3'd0, 32'h40000000, 1'b0, 1'b0);
                put(32'h40000000, 32'h3FC00000, 3'd0, 32'h40400000, 1'b0, 1'b0);
                put(32'h40000000, 32'h40400000, 3'd0, 32'h40C00000, 1'b0, 1'b0);
                put(32'h40000000, 32'h3F000000, 3'd0, 32'h3F800000, 1'b0, 1'b0);
                put(32'h40000000, 32'hC0000000, 3'd0, 32'hC0800000, 1'b0, 1'b0);
                put(32'h40000000, 32'h3FA00000, 3'd0, 32'h40200000, 1'b0, 1'b0);
            end
            begin
                repeat (4) @(negedge clk);
                check("bp_in_ready_full", 64'(in_ready),  64'd0);
                check("bp_out_valid",     64'(out_valid), 64'd1);
                check("bp_z_first",       64'(fp_Z),      64'h40000000);
                repeat (3) @(negedge clk);
                check("bp_in_ready_held", 64'(in_ready),  64'd0);
                check("bp_z_held",        64'(fp_Z),      64'h40000000);
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain("drain_backpressure");

        // reset with three operations held in the pipeline
        out_ready = 1'b0;
        put(32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 1'b0, 1'b0);
        put(32'h40000000, 32'h40000000, 3'd0, 32'h40800000, 1'b0, 1'b0);
        put(32'h3F800000, 32'h3F800000, 3'd0, 32'h3F800000, 1'b0, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_in_ready",  64'(in_ready),  64'd1);
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid)
                stale++;
        end
        check("rst_mid_no_stale", 64'(stale), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
